sasa_lm_scheduler: RTL

Sequencer that drains a CAM OR-match vector one match at a time, highest index first. It feeds the leading-match datapath stage of the SASA lookup path. The block latches the match vector from the CAM and issues each set bit as an index plus a one-hot vector over a valid/ready handshake. It can stop after a programmable top-k count, and it reports a running leading-match counter.

---
 rtl/sasa_lm_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sasa_lm_scheduler.sv
// Leading-match scheduler: latches a CAM OR-match vector and issues its set bits highest index first.
// Optional top-k early termination is compiled in with `SASA_LM_SCHED_TOPK_EN.
`ifndef SASA_CAM_len
`define SASA_CAM_len 256
`endif

module sasa_lm_scheduler #(
  parameter int LEN = `SASA_CAM_len,
  parameter int IW  = $clog2(LEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [LEN-1:0] or_match_vector,
  input  logic [7:0]     topk,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IW-1:0]  out_index,
  output logic [LEN-1:0] out_onehot,
  output logic           out_last,
  output logic [8:0]     lm_counter,
  output logic           done,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t         state;
  logic [LEN-1:0] rem;
  logic [LEN-1:0] rem_clr;
  logic [IW-1:0]  start_idx;
  logic [IW-1:0]  next_idx;
  logic           start_single;
  logic           next_single;
  logic           start_limit;
  logic           next_limit;

  function automatic logic [IW-1:0] highest_bit(input logic [LEN-1:0] vec);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < LEN; i++) begin
      if (vec[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  function automatic logic one_bit(input logic [LEN-1:0] vec);
    return (vec != '0) && ((vec & (vec - LEN'(1))) == '0);
  endfunction

  function automatic logic [LEN-1:0] onehot_of(input logic [IW-1:0] idx);
    return LEN'(1) << idx;
  endfunction

  // The next issue is precomputed from rem with the current bit removed, so outputs stay registered.
  assign rem_clr      = rem & ~out_onehot;
  assign start_idx    = highest_bit(or_match_vector);
  assign next_idx     = highest_bit(rem_clr);
  assign start_single = one_bit(or_match_vector);
  assign next_single  = one_bit(rem_clr);

`ifdef SASA_LM_SCHED_TOPK_EN
  logic [7:0] k;
  assign start_limit = (topk == 8'd1);
  assign next_limit  = (k != 8'd0) && ({1'b0, k} == lm_counter + 9'd2);
`else
  logic unused_topk;
  assign unused_topk = ^topk;
  assign start_limit = 1'b0;
  assign next_limit  = 1'b0;
`endif

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem        <= '0;
      lm_counter <= '0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_onehot <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
`ifdef SASA_LM_SCHED_TOPK_EN
      k          <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_valid) begin
            rem        <= or_match_vector;
            lm_counter <= '0;
`ifdef SASA_LM_SCHED_TOPK_EN
            k          <= topk;
`endif
            if (or_match_vector == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= ISSUE;
              out_valid  <= 1'b1;
              out_index  <= start_idx;
              out_onehot <= onehot_of(start_idx);
              out_last   <= start_single || start_limit;
            end
          end
        end
        ISSUE: begin
          // Abort wins over a same-cycle handshake, so the counter is left untouched.
          if (abort) begin
            state      <= IDLE;
            rem        <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_onehot <= '0;
            out_last   <= 1'b0;
          end else if (out_ready) begin
            rem        <= rem_clr;
            lm_counter <= lm_counter + 9'd1;
            if (out_last) begin
              state      <= DONE;
              done       <= 1'b1;
              out_valid  <= 1'b0;
              out_index  <= '0;
              out_onehot <= '0;
              out_last   <= 1'b0;
            end else begin
              out_index  <= next_idx;
              out_onehot <= onehot_of(next_idx);
              out_last   <= next_single || next_limit;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          rem   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
